// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parameterised pipeline register chain (1..4 stages) with
// stall, flush-to-bubble and a saturating counter of bubbles loaded.
// Each stage carries {valid, ctrl, waddr, data}; the outputs come straight
// from the last stage, so there is no combinational input-to-output path.
module pipe_stage_reg #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 3,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [ADDR_W-1:0] waddr_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [ADDR_W-1:0] waddr_out,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // ------------------------------------------------------------------
    // Configuration guard: only 1..4 stages are supported.
    // ------------------------------------------------------------------
    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
        $error("pipe_stage_reg: DEPTH=%0d is outside the legal range 1..4", DEPTH);
    end

    // Saturation limit and increment constant for the bubble counter.
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // Stage storage: index 0 is the entry stage, DEPTH-1 drives the outputs.
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DEPTH-1:0][ADDR_W-1:0] waddr_q, waddr_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q,  data_d;

    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Entry-stage values with write-enable fields gated by valid, so an
    // invalid entry never carries register-write or memory-write bits.
    logic [CTRL_W-1:0] ctrl_gated;
    logic [ADDR_W-1:0] waddr_gated;

    // A bubble is loaded on any flush, or on an advance with no valid input.
    logic bubble_load;

    // Gate control and destination of the incoming entry by its valid bit.
    always_comb begin
        ctrl_gated  = valid_in ? ctrl_in  : '0;
        waddr_gated = valid_in ? waddr_in : '0;
        bubble_load = flush | (~stall & ~valid_in);
    end

    // Next-state for all stages: flush > stall > normal advance.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        waddr_d = waddr_q;
        data_d  = data_q;

        if (flush) begin
            // Kill every entry; payload is left untouched since it is
            // meaningless once valid is low and holding it saves toggling.
            valid_d = '0;
            ctrl_d  = '0;
            waddr_d = '0;
        end else if (!stall) begin
            valid_d[0] = valid_in;
            ctrl_d[0]  = ctrl_gated;
            waddr_d[0] = waddr_gated;
            data_d[0]  = data_in;
            for (int k = 1; k < DEPTH; k++) begin
                valid_d[k] = valid_q[k-1];
                ctrl_d[k]  = ctrl_q[k-1];
                waddr_d[k] = waddr_q[k-1];
                data_d[k]  = data_q[k-1];
            end
        end
    end

    // Next-state for the bubble counter: one step per edge, saturating.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_load && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_ONE;
        end
    end

    // State registers with synchronous reset that overrides flush and stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the payload is reset as well as the control fields, so
            // the outputs read all-zero after reset rather than stale data.
            valid_q      <= '0;
            ctrl_q       <= '0;
            waddr_q      <= '0;
            data_q       <= '0;
            bubble_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the
            // previous-cycle value of its neighbour, which is what shifts.
            valid_q      <= valid_d;
            ctrl_q       <= ctrl_d;
            waddr_q      <= waddr_d;
            data_q       <= data_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Outputs are the last stage registers directly.
    assign valid_out  = valid_q[DEPTH-1];
    assign ctrl_out   = ctrl_q[DEPTH-1];
    assign waddr_out  = waddr_q[DEPTH-1];
    assign data_out   = data_q[DEPTH-1];
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: four instances share one stimulus
// stream (DEPTH=1, DEPTH=3, DEPTH=2, and DEPTH=1 with a 4-bit counter).
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        valid_in;
    logic [2:0]  ctrl_in;
    logic [4:0]  waddr_in;
    logic [63:0] data_in;

    logic        v1, v3, v2, vc;
    logic [2:0]  c1, c3, c2, cc;
    logic [4:0]  w1, w3, w2, wc;
    logic [63:0] d1, d3, d2, dc;
    logic [15:0] b1, b3, b2;
    logic [3:0]  bc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DEPTH(1)) u_d1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_in(valid_in), .ctrl_in(ctrl_in), .waddr_in(waddr_in), .data_in(data_in),
        .valid_out(v1), .ctrl_out(c1), .waddr_out(w1), .data_out(d1), .bubble_cnt(b1)
    );

    pipe_stage_reg #(.DEPTH(3)) u_d3 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_in(valid_in), .ctrl_in(ctrl_in), .waddr_in(waddr_in), .data_in(data_in),
        .valid_out(v3), .ctrl_out(c3), .waddr_out(w3), .data_out(d3), .bubble_cnt(b3)
    );

    pipe_stage_reg #(.DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_in(valid_in), .ctrl_in(ctrl_in), .waddr_in(waddr_in), .data_in(data_in),
        .valid_out(v2), .ctrl_out(c2), .waddr_out(w2), .data_out(d2), .bubble_cnt(b2)
    );

    pipe_stage_reg #(.DEPTH(1), .CNT_W(4)) u_c4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .valid_in(valid_in), .ctrl_in(ctrl_in), .waddr_in(waddr_in), .data_in(data_in),
        .valid_out(vc), .ctrl_out(cc), .waddr_out(wc), .data_out(dc), .bubble_cnt(bc)
    );

    // One comparison: counts it, asserts equality, reports on mismatch.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [4:0] w,
                         input logic [63:0] d);
        valid_in = v;
        ctrl_in  = c;
        waddr_in = w;
        data_in  = d;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b0, 3'b000, 5'd0, 64'h0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drive(1'b1, 3'b111, 5'd31, 64'hFFFF);
        step();
        step();
        rst = 1'b0;
        drive(1'b0, 3'b000, 5'd0, 64'h0);

        // Reset state: everything reads zero.
        check("rst_d1_valid", 64'(v1), 64'h0);
        check("rst_d1_ctrl",  64'(c1), 64'h0);
        check("rst_d1_waddr", 64'(w1), 64'h0);
        check("rst_d1_data",  d1,      64'h0);
        check("rst_d1_bcnt",  64'(b1), 64'h0);
        check("rst_d3_valid", 64'(v3), 64'h0);
        check("rst_d3_data",  d3,      64'h0);

        // Pass-through, DEPTH=1.
        drive(1'b1, 3'b101, 5'd9, 64'h1234);
        step();
        check("pt_valid", 64'(v1), 64'h1);
        check("pt_ctrl",  64'(c1), 64'h5);
        check("pt_waddr", 64'(w1), 64'd9);
        check("pt_data",  d1,      64'h1234);
        check("pt_bcnt",  64'(b1), 64'h0);

        // Latency, DEPTH=3: A, B, C back to back, then invalid entries
        // carrying ctrl=111 / waddr=31 that must emerge gated to zero.
        do_reset();
        drive(1'b1, 3'b001, 5'd1, 64'hA);
        step();
        check("lat_e1_valid", 64'(v3), 64'h0);
        drive(1'b1, 3'b010, 5'd2, 64'hB);
        step();
        check("lat_e2_valid", 64'(v3), 64'h0);
        drive(1'b1, 3'b011, 5'd3, 64'hC);
        step();
        check("lat_A_valid", 64'(v3), 64'h1);
        check("lat_A_data",  d3,      64'hA);
        check("lat_A_ctrl",  64'(c3), 64'h1);
        drive(1'b0, 3'b111, 5'd31, 64'h0);
        step();
        check("lat_B_data",  d3,      64'hB);
        check("lat_B_waddr", 64'(w3), 64'd2);
        check("inv_d1_valid", 64'(v1), 64'h0);
        check("inv_d1_ctrl",  64'(c1), 64'h0);
        check("inv_d1_waddr", 64'(w1), 64'h0);
        step();
        check("lat_C_valid", 64'(v3), 64'h1);
        check("lat_C_data",  d3,      64'hC);
        step();
        check("inv_d3_valid", 64'(v3), 64'h0);
        check("inv_d3_ctrl",  64'(c3), 64'h0);
        check("inv_d3_waddr", 64'(w3), 64'h0);
        check("inv_d3_bcnt",  64'(b3), 64'd3);

        // Stall, DEPTH=2: A, B in flight; two stalled edges with a new
        // input that must never appear.
        do_reset();
        drive(1'b1, 3'b010, 5'd2, 64'hA);
        step();
        drive(1'b1, 3'b100, 5'd4, 64'hB);
        step();
        check("stl_pre_data", d2, 64'hA);
        stall = 1'b1;
        drive(1'b1, 3'b111, 5'd7, 64'hDEAD);
        step();
        check("stl_c1_valid", 64'(v2), 64'h1);
        check("stl_c1_data",  d2,      64'hA);
        step();
        check("stl_c2_data",  d2,      64'hA);
        check("stl_c2_ctrl",  64'(c2), 64'h2);
        check("stl_c2_waddr", 64'(w2), 64'd2);
        check("stl_c2_bcnt",  64'(b2), 64'h0);
        stall = 1'b0;
        drive(1'b0, 3'b000, 5'd0, 64'h5);
        step();
        check("stl_B_data",  d2,      64'hB);
        check("stl_B_ctrl",  64'(c2), 64'h4);
        step();
        check("stl_bub_valid", 64'(v2), 64'h0);
        check("stl_bub_data",  d2,      64'h5);
        check("stl_bub_bcnt",  64'(b2), 64'd2);

        // Flush together with stall while data_out=ABCD.
        do_reset();
        drive(1'b1, 3'b101, 5'd4, 64'hABCD);
        step();
        check("fl_pre_data", d1, 64'hABCD);
        flush = 1'b1;
        stall = 1'b1;
        drive(1'b1, 3'b011, 5'd6, 64'h1111);
        step();
        flush = 1'b0;
        stall = 1'b0;
        check("fl_valid", 64'(v1), 64'h0);
        check("fl_ctrl",  64'(c1), 64'h0);
        check("fl_waddr", 64'(w1), 64'h0);
        check("fl_data",  d1,      64'hABCD);
        check("fl_bcnt",  64'(b1), 64'h1);
        check("fl_d3_bcnt", 64'(b3), 64'h1);

        // Reset with entries in flight discards them (DEPTH=3).
        do_reset();
        drive(1'b1, 3'b110, 5'd12, 64'h77);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drive(1'b0, 3'b000, 5'd0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rif_valid", 64'(v3), 64'h0);
            check("rif_data",  d3,      64'h0);
        end

        // Saturation, CNT_W=4: 20 invalid cycles, then a reset mid-run.
        do_reset();
        drive(1'b0, 3'b000, 5'd0, 64'h0);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 10) check("sat_10", 64'(bc), 64'd10);
            if (i == 15) check("sat_15", 64'(bc), 64'd15);
        end
        check("sat_20", 64'(bc), 64'd15);
        rst = 1'b1;
        step();
        check("sat_rst", 64'(bc), 64'd0);
        rst = 1'b0;
        step();
        check("sat_after_rst", 64'(bc), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
